// File: rtl/rptr_empty_lvl_if.sv
// Read-side port bundle of the async FIFO pointer/flag controller.
// Latency: none, wires only. Backpressure: none; rinc is gated by rempty inside the controller.
// Parameter ADDRSIZE must match the controller it connects to.
interface rptr_empty_lvl_if #(
    parameter int ADDRSIZE = 8
);
    logic                rinc;
    logic                uclr;
    logic [ADDRSIZE:0]   rq2_wptr;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic                raempty;
    logic [ADDRSIZE:0]   rlevel;
    logic                runderflow;

    modport master (
        output rinc, uclr, rq2_wptr,
        input  raddr, rptr, rempty, raempty, rlevel, runderflow
    );

    modport slave (
        input  rinc, uclr, rq2_wptr,
        output raddr, rptr, rempty, raempty, rlevel, runderflow
    );
endinterface

// File: rtl/rptr_empty_lvl.sv
// Async FIFO read-side pointer, empty/almost-empty flags, fill level and sticky underflow (rclk domain).
// Latency: flags, level and pointers registered, updated on the edge of the pop; raddr has no extra delay.
// Backpressure: pops while empty are ignored and latch runderflow. Macro RPTR_LEVEL_EN builds rlevel/raempty.
module rptr_empty_lvl #(
    parameter int ADDRSIZE      = 8,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic            rclk,
    input  logic            rrst_n,
    rptr_empty_lvl_if.slave bus
);
    localparam int PW = ADDRSIZE + 1;

    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > (1 << ADDRSIZE)) begin : g_thresh_range
        $error("AEMPTY_THRESH outside 0..2**ADDRSIZE");
    end

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbinnext;
    logic [PW-1:0] rgraynext;
    logic [PW-1:0] rptr_q;
    logic          rempty_q;
    logic          runderflow_q;
    logic          pop;
    logic          underflow;

    always_comb begin
        pop       = bus.rinc & ~rempty_q;
        underflow = bus.rinc & rempty_q;
        rbinnext  = rbin + PW'(pop);
        rgraynext = (rbinnext >> 1) ^ rbinnext;
    end

    // Empty compares the next pointer so the flag rises on the edge of the last pop.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin         <= '0;
            rptr_q       <= '0;
            rempty_q     <= 1'b1;
            runderflow_q <= 1'b0;
        end else begin
            rbin     <= rbinnext;
            rptr_q   <= rgraynext;
            rempty_q <= (rgraynext == bus.rq2_wptr);
            if (underflow)
                runderflow_q <= 1'b1;
            else if (bus.uclr)
                runderflow_q <= 1'b0;
        end
    end

    assign bus.raddr      = rbin[ADDRSIZE-1:0];
    assign bus.rptr       = rptr_q;
    assign bus.rempty     = rempty_q;
    assign bus.runderflow = runderflow_q;

`ifdef RPTR_LEVEL_EN
    localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

    logic [PW-1:0] wbin_s;
    logic [PW-1:0] lvl_next;
    logic [PW-1:0] rlevel_q;
    logic          raempty_q;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i < PW; i++)
            wbin_s[i] = ^(bus.rq2_wptr >> i);
        lvl_next = wbin_s - rbinnext;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rlevel_q  <= '0;
            raempty_q <= 1'b1;
        end else begin
            rlevel_q  <= lvl_next;
            raempty_q <= (lvl_next <= AE_TH);
        end
    end

    assign bus.rlevel  = rlevel_q;
    assign bus.raempty = raempty_q;
`else
    assign bus.rlevel  = '0;
    assign bus.raempty = rempty_q;
`endif
endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Directed bench for rptr_empty_lvl (ADDRSIZE=4, AEMPTY_THRESH=2) with a queued expected-value scoreboard.
module tb_rptr_empty_lvl;
    localparam int AW = 4;
    localparam int PW = AW + 1;
`ifdef RPTR_LEVEL_EN
    localparam bit LVL = 1'b1;
`else
    localparam bit LVL = 1'b0;
`endif

    typedef struct packed {
        logic [PW-1:0] rptr;
        logic [AW-1:0] raddr;
        logic          rempty;
        logic          raempty;
        logic [PW-1:0] rlevel;
        logic          runderflow;
    } exp_t;

    logic rclk;
    logic rrst_n;
    rptr_empty_lvl_if #(.ADDRSIZE(AW)) ifc ();

    rptr_empty_lvl #(.ADDRSIZE(AW), .AEMPTY_THRESH(2)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (ifc)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    exp_t  exp_q[$];
    string tag_q[$];
    int    nvec = 0;
    int    nerr = 0;

    // Reference state, written independently of the RTL structure.
    int m_bin = 0;
    bit m_empty = 1'b1;
    bit m_und = 1'b0;

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & 31;
    endfunction

    function automatic int from_gray(input int g);
        int b = 0;
        int acc = 0;
        for (int k = PW - 1; k >= 0; k--) begin
            acc = acc ^ ((g >> k) & 1);
            b = b | (acc << k);
        end
        return b;
    endfunction

    task automatic chk(input string tag, input string fld, input logic [PW-1:0] got, input logic [PW-1:0] want);
        nvec++;
        assert (got === want)
        else begin
            nerr++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, got, want);
        end
    endtask

    task automatic check_outputs();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, "rptr",       ifc.rptr,                e.rptr);
        chk(t, "raddr",      PW'(ifc.raddr),          PW'(e.raddr));
        chk(t, "rempty",     PW'(ifc.rempty),         PW'(e.rempty));
        chk(t, "raempty",    PW'(ifc.raempty),        PW'(e.raempty));
        chk(t, "rlevel",     ifc.rlevel,              e.rlevel);
        chk(t, "runderflow", PW'(ifc.runderflow),     PW'(e.runderflow));
    endtask

    task automatic step(input bit i_rinc, input bit i_uclr, input int i_wbin, input string tag);
        exp_t e;
        int   wg, nbin, lvl;
        bit   pop;
        @(negedge rclk);
        wg = to_gray(i_wbin & 31);
        ifc.rinc     = i_rinc;
        ifc.uclr     = i_uclr;
        ifc.rq2_wptr = PW'(wg);
        pop  = i_rinc && !m_empty;
        nbin = (m_bin + (pop ? 1 : 0)) % 32;
        lvl  = (from_gray(wg) - nbin + 32) % 32;
        if (i_rinc && m_empty) m_und = 1'b1;
        else if (i_uclr)       m_und = 1'b0;
        m_empty = (to_gray(nbin) == wg);
        m_bin   = nbin;
        e.rptr       = PW'(to_gray(nbin));
        e.raddr      = AW'(nbin % 16);
        e.rempty     = m_empty;
        e.raempty    = LVL ? (lvl <= 2) : m_empty;
        e.rlevel     = LVL ? PW'(lvl) : '0;
        e.runderflow = m_und;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge rclk);
        #1;
        check_outputs();
    endtask

    task automatic reset_now();
        exp_t e;
        #2 rrst_n = 1'b0;
        #1;
        m_bin = 0; m_empty = 1'b1; m_und = 1'b0;
        e = '{rptr: '0, raddr: '0, rempty: 1'b1, raempty: 1'b1, rlevel: '0, runderflow: 1'b0};
        exp_q.push_back(e);
        tag_q.push_back("reset");
        check_outputs();
        @(negedge rclk);
        ifc.rinc = 1'b0;
        ifc.uclr = 1'b0;
        ifc.rq2_wptr = '0;
        rrst_n = 1'b1;
    endtask

    initial begin
        rrst_n = 1'b1;
        ifc.rinc = 1'b0;
        ifc.uclr = 1'b0;
        ifc.rq2_wptr = '0;
        reset_now();

        // Drain three entries; empty rises on the third pop edge.
        step(0, 0, 3, "drain_load");
        step(1, 0, 3, "drain_pop0");
        step(1, 0, 3, "drain_pop1");
        step(1, 0, 3, "drain_pop2");
        chk("drain_const", "rptr", ifc.rptr, 5'b00010);

        // Underflow: sticky, cleared by uclr, set wins over uclr.
        step(1, 0, 3, "uflow_set");
        step(0, 0, 3, "uflow_hold");
        step(0, 1, 3, "uflow_clr");
        step(1, 1, 3, "uflow_setwins");
        step(0, 1, 3, "uflow_clr2");

        // Simultaneous pop and write-pointer advance.
        step(0, 0, 6, "simul_load");
        step(1, 0, 8, "simul_pop_upd");
        step(1, 0, 9, "simul_pop_upd2");

        // Mid-traffic reset, then the full-FIFO view.
        @(negedge rclk);
        ifc.rinc = 1'b1;
        reset_now();
        step(0, 0, 16, "full_view");
        for (int k = 0; k < 16; k++)
            step(1, 0, 16, $sformatf("full_drain%0d", k));

        // Refill through wrap point, then pop to rbin=31 and across the wrap.
        step(0, 0, 32, "wrap_load");
        for (int k = 0; k < 15; k++)
            step(1, 0, 32, $sformatf("wrap_pop%0d", k));
        chk("wrap_pre", "rptr", ifc.rptr, 5'b10000);
        step(1, 0, 32, "wrap_cross");
        chk("wrap_post", "rptr", ifc.rptr, 5'b00000);
        step(1, 0, 32, "wrap_uflow");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
